// File: rtl/tea_pkg.sv
// Purpose: shared types, constants and the TEA mixing function for the TEA block engine.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: width localparams, default DELTA, v0/v1 and k0..k3 slice positions, FSM state enum, tea_f.
package tea_pkg;

    localparam int WORD_W  = 32;
    localparam int BLOCK_W = 64;
    localparam int KEY_W   = 128;

    localparam logic [WORD_W-1:0] TEA_DELTA = 32'h9E3779B9;

    // Word positions inside the packed block and key buses (LSB of each 32-bit word).
    localparam int V0_LSB = 32;
    localparam int V1_LSB = 0;
    localparam int K0_LSB = 96;
    localparam int K1_LSB = 64;
    localparam int K2_LSB = 32;
    localparam int K3_LSB = 0;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HALF_A = 2'd1,
        ST_HALF_B = 2'd2,
        ST_DONE   = 2'd3
    } tea_state_t;

    // F(x, ka, kb, s) = ((x<<4)+ka) ^ (x+s) ^ ((x>>5)+kb), all modulo 2^32, logical shift.
    function automatic word_t tea_f(input word_t x, input word_t ka,
                                    input word_t kb, input word_t s);
        return ((x << 4) + ka) ^ (x + s) ^ ((x >> 5) + kb);
    endfunction

endpackage

// File: rtl/tea_block_engine_if.sv
// Purpose: request/result stream bundle between the host-side loader and the TEA engine.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
// Signals: in_valid, in_ready, in_decrypt, in_block[63:0], in_key[127:0],
//          out_valid, out_ready, out_block[63:0], busy.
// Modports: master = loader/consumer side, slave = engine side.
interface tea_block_engine_if;

    logic                         in_valid;
    logic                         in_ready;
    logic                         in_decrypt;
    logic [tea_pkg::BLOCK_W-1:0]  in_block;
    logic [tea_pkg::KEY_W-1:0]    in_key;
    logic                         out_valid;
    logic                         out_ready;
    logic [tea_pkg::BLOCK_W-1:0]  out_block;
    logic                         busy;

    modport master (
        output in_valid, in_decrypt, in_block, in_key, out_ready,
        input  in_ready, out_valid, out_block, busy
    );

    modport slave (
        input  in_valid, in_decrypt, in_block, in_key, out_ready,
        output in_ready, out_valid, out_block, busy
    );

endinterface

// File: rtl/tea_half_round.sv
// Purpose: one TEA half round, y' = y +/- F(x, ka, kb, s); purely combinational.
// Latency: 0 cycles.
// Backpressure: none (no state).
// Ports: x/ka/kb/s feed F, y is the word being updated, sub selects subtract (decrypt), y_nxt is the result.
module tea_half_round
    import tea_pkg::*;
(
    input  word_t x,
    input  word_t ka,
    input  word_t kb,
    input  word_t s,
    input  word_t y,
    input  logic  sub,
    output word_t y_nxt
);

    word_t f_val;

    assign f_val = tea_f(x, ka, kb, s);
    assign y_nxt = sub ? (y - f_val) : (y + f_val);

endmodule

// File: rtl/tea_block_engine.sv
// Purpose: iterative TEA encrypt/decrypt of one 64-bit block under a 128-bit key per request.
// Latency: out_valid rises 2*ROUNDS edges after the acceptance edge; one half round per cycle.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, so requests never overlap.
// Ports: clk, reset (synchronous, active high), bus (slave side of tea_block_engine_if).
// Parameters: ROUNDS = full TEA cycles (legal 1..63), DELTA = key-schedule constant.
module tea_block_engine
    import tea_pkg::*;
#(
    parameter int    ROUNDS = 32,
    parameter word_t DELTA  = TEA_DELTA
) (
    input logic                clk,
    input logic                reset,
    tea_block_engine_if.slave  bus
);

    localparam int              CNT_W    = $clog2(ROUNDS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROUNDS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // Decrypt walks the sum backwards from its final encrypt value.
    localparam word_t           SUM_DEC  = DELTA * 32'(ROUNDS);

    tea_state_t         state, state_nxt;
    word_t              v0, v1, sum;
    logic [KEY_W-1:0]   key;
    logic               mode_dec;
    logic [CNT_W-1:0]   rnd_cnt;
    logic               out_valid_q;
    logic [BLOCK_W-1:0] out_block_q;

    logic  last_half;
    logic  upd_v0;
    word_t sum_inc;
    word_t hr_x, hr_ka, hr_kb, hr_s, hr_y, hr_y_nxt;

    assign last_half = (state == ST_HALF_B) && (rnd_cnt == LAST_CNT);

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (bus.in_valid) state_nxt = ST_HALF_A;
            ST_HALF_A: state_nxt = ST_HALF_B;
            ST_HALF_B: state_nxt = last_half ? ST_DONE : ST_HALF_A;
            ST_DONE:   if (bus.out_ready) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- shared half-round operands ----------------
    // Encrypt updates v0 in HALF_A and v1 in HALF_B; decrypt does the reverse.
    // The word being updated always mixes the other word with the key pair
    // that belongs to it (v0 with k0/k1, v1 with k2/k3).
    assign upd_v0  = (state == ST_HALF_A) ^ mode_dec;
    assign sum_inc = sum + DELTA;

    always_comb begin
        hr_x  = upd_v0 ? v1 : v0;
        hr_y  = upd_v0 ? v0 : v1;
        hr_ka = upd_v0 ? key[K0_LSB +: WORD_W] : key[K2_LSB +: WORD_W];
        hr_kb = upd_v0 ? key[K1_LSB +: WORD_W] : key[K3_LSB +: WORD_W];
        // Encrypt HALF_A consumes the freshly advanced sum in the same cycle.
        hr_s  = ((state == ST_HALF_A) && !mode_dec) ? sum_inc : sum;
    end

    tea_half_round u_half_round (
        .x     (hr_x),
        .ka    (hr_ka),
        .kb    (hr_kb),
        .s     (hr_s),
        .y     (hr_y),
        .sub   (mode_dec),
        .y_nxt (hr_y_nxt)
    );

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            v0          <= '0;
            v1          <= '0;
            key         <= '0;
            mode_dec    <= 1'b0;
            sum         <= '0;
            rnd_cnt     <= '0;
            out_valid_q <= 1'b0;
            out_block_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        v0       <= bus.in_block[V0_LSB +: WORD_W];
                        v1       <= bus.in_block[V1_LSB +: WORD_W];
                        key      <= bus.in_key;
                        mode_dec <= bus.in_decrypt;
                        sum      <= bus.in_decrypt ? SUM_DEC : '0;
                        rnd_cnt  <= '0;
                    end
                end
                ST_HALF_A: begin
                    if (upd_v0) v0 <= hr_y_nxt;
                    else        v1 <= hr_y_nxt;
                    if (!mode_dec) sum <= sum_inc;
                end
                ST_HALF_B: begin
                    if (upd_v0) v0 <= hr_y_nxt;
                    else        v1 <= hr_y_nxt;
                    if (mode_dec) sum <= sum - DELTA;
                    rnd_cnt <= rnd_cnt + CNT_ONE;
                    if (last_half) begin
                        out_valid_q <= 1'b1;
                        out_block_q <= upd_v0 ? {hr_y_nxt, v1} : {v0, hr_y_nxt};
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) out_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // ---------------- outputs ----------------
    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.busy      = (state != ST_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_block = out_block_q;

endmodule
